dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

Load/store initiator that sits between the single-cycle datapath's memory stage and the data memory bank. It accepts one byte/half/word load or store request at a time and drives the memory's memread/memwrite/address/writedata interface. It returns aligned, sign- or zero-extended load data, and performs read-modify-write for sub-word stores on the word-only memory. It also flags misaligned and out-of-range accesses without touching memory.

## Interface
- DATA_W, 32, data width of CPU side and memory side
- DEPTH, 128, memory depth in words; valid word indices 0..DEPTH-1
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result (0 for stores and errors)
- resp_err  out  1  qualifies resp_valid: access rejected
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- address  out  32  memory word index (req_addr >> 2)
- writedata  out  32  memory write word
- readdata  in  32  memory read word, combinational from address

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE: req_ready = 1. On req_valid, latch all request fields and classify:
  - error if size 11, half with addr[0]=1, word with addr[1:0]≠0, or addr>>2 ≥ DEPTH → RESP with err
  - load → RD
  - word store → WR
  - byte/half store → RMW_RD
- RD: memread=1; at the edge, capture readdata, extract the lane, extend, → RESP.
- WR: memwrite=1, writedata=req_wdata → RESP.
- RMW_RD: memread=1; capture readdata, merge the store lane → RMW_WR.
- RMW_WR: memwrite=1 with the merged word → RESP.
- RESP: resp_valid=1 for exactly one cycle (no backpressure) → IDLE.
- Lanes are little-endian: byte lane = addr[1:0], half lane = addr[1]. Extension uses the lane MSB when req_signed=1, else zero.
- memread, memwrite, address and writedata are registered and glitch-free, because the memory is level-sensitive. memread and memwrite are never high together.
- req_valid is ignored while not IDLE.

## Timing
- Accept at edge N. Memory strobe during cycle N+1.
  - Load and word store: resp_valid during N+2.
  - Sub-word store: read during N+1, write during N+2, resp_valid during N+3.
  - Error: resp_valid during N+1, zero memory strobes.
- Each strobe is high for exactly one cycle. address and writedata are stable for that whole cycle.
- Throughput: the next request can be accepted in the cycle after RESP.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, memread 0, memwrite 0, address 0, writedata 0.
- Reset mid-operation: strobes drop immediately (asynchronously) and the pending request is discarded with no response. A write already strobed in that cycle may have reached memory.

## Configuration
- DMEM_SUBWORD_EN defined: byte/half loads and stores are supported, including the RMW states.
- DMEM_SUBWORD_EN undefined:
  - only word accesses; req_size ≠ 10 → resp_err
  - RMW_RD/RMW_WR and lane logic are removed; resp_rdata = readdata directly

## Structure
- Package dmem_pkg holds: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum, and the DEPTH default.
- Sub-module dmem_lane_align holds the combinational load extract/extend and store merge, shared by RD and RMW_RD.

## Test plan
Memory is preloaded with mem[i] = i*10.
- Load word 0x14 → memread high one cycle with address=5; resp_valid two cycles after accept; resp_rdata=50.
- Store word 0xDEADBEEF at 0x20, then load 0x20 → memwrite high one cycle with address=8; load returns 0xDEADBEEF.
- Store byte 0xAB at 0x29 (word 10 = 0x64) → word becomes 0x0000AB64. Signed byte load at 0x29 → 0xFFFFFFAB; unsigned → 0x000000AB; resp_valid three cycles after the store is accepted.
- Word load 0x16 → resp_err=1 one cycle after accept, resp_rdata=0, no strobes. Word load 0x200 → same error behaviour.
- Assert rst during the WR cycle → memwrite falls without waiting for an edge; no resp_valid; req_ready=1 while rst is high.
- Without DMEM_SUBWORD_EN, a half load at 0x04 → resp_err=1 and no memread.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, FSM states,
// default memory depth and the alignment rule used to classify requests.
package dmem_pkg;

   localparam int unsigned DMEM_DEPTH = 128;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_RMW_RD,
      ST_RMW_WR,
      ST_RESP
   } state_e;

   // True when the size code is illegal or the low address bits break its alignment.
   function automatic logic is_bad_align(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SZ_BYTE: is_bad_align = 1'b0;
         SZ_HALF: is_bad_align = lo[0];
         SZ_WORD: is_bad_align = (lo != 2'b00);
         default: is_bad_align = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane logic: extracts and extends a byte/half/word from a memory
// word for loads, and merges store data into a word for read-modify-write.
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] i_word,
   input  logic [1:0]        i_lo,
   input  logic [1:0]        i_size,
   input  logic              i_signed,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_load,
   output logic [DATA_W-1:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_byte = 8'h00;
      case (i_lo)
         2'd0: w_byte = i_word[7:0];
         2'd1: w_byte = i_word[15:8];
         2'd2: w_byte = i_word[23:16];
         2'd3: w_byte = i_word[31:24];
         default: w_byte = 8'h00;
      endcase
      w_half = i_lo[1] ? i_word[31:16] : i_word[15:0];

      o_load = i_word;
      case (i_size)
         SZ_BYTE: o_load = {{(DATA_W-8){i_signed & w_byte[7]}}, w_byte};
         SZ_HALF: o_load = {{(DATA_W-16){i_signed & w_half[15]}}, w_half};
         default: o_load = i_word;
      endcase
   end

   always_comb begin
      o_merged = i_word;
      case (i_size)
         SZ_BYTE: begin
            case (i_lo)
               2'd0: o_merged[7:0]   = i_wdata[7:0];
               2'd1: o_merged[15:8]  = i_wdata[7:0];
               2'd2: o_merged[23:16] = i_wdata[7:0];
               2'd3: o_merged[31:24] = i_wdata[7:0];
               default: o_merged = i_word;
            endcase
         end
         SZ_HALF: begin
            if (i_lo[1]) o_merged[31:16] = i_wdata[15:0];
            else         o_merged[15:0]  = i_wdata[15:0];
         end
         default: o_merged = i_wdata;
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store initiator for a word-only data memory with registered, glitch-free strobes.
// Define DMEM_SUBWORD_EN to enable byte/half accesses (extract/extend and read-modify-write).
module dmem_access_unit
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = DMEM_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              memread,
   output logic              memwrite,
   output logic [31:0]       address,
   output logic [DATA_W-1:0] writedata,
   input  logic [DATA_W-1:0] readdata
);

   state_e r_state;
   state_e w_next;

   logic              r_memread;
   logic              r_memwrite;
   logic [31:0]       r_address;
   logic [DATA_W-1:0] r_writedata;
   logic              r_resp_valid;
   logic              r_resp_err;
   logic [DATA_W-1:0] r_resp_rdata;

   logic [31:0]       w_word_idx;
   logic              w_req_err;
   logic [DATA_W-1:0] w_load_data;
   logic              w_accept;

   assign w_accept   = (r_state == ST_IDLE) && req_valid;
   assign w_word_idx = req_addr >> 2;

`ifdef DMEM_SUBWORD_EN
   logic [1:0]        r_size;
   logic              r_signed;
   logic [1:0]        r_lo;
   logic [DATA_W-1:0] w_merged;

   assign w_req_err = is_bad_align(req_size, req_addr[1:0]) || (w_word_idx >= 32'(DEPTH));

   dmem_lane_align #(.DATA_W(DATA_W)) u_lane (
      .i_word   (readdata),
      .i_lo     (r_lo),
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_wdata  (r_writedata),
      .o_load   (w_load_data),
      .o_merged (w_merged)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_size   <= SZ_WORD;
         r_signed <= 1'b0;
         r_lo     <= 2'b00;
      end else if (w_accept) begin
         r_size   <= req_size;
         r_signed <= req_signed;
         r_lo     <= req_addr[1:0];
      end
   end
`else
   logic w_unused_signed;

   // Word-only build: anything but an aligned in-range word is rejected.
   assign w_req_err = (req_size != SZ_WORD) || (req_addr[1:0] != 2'b00) ||
                      (w_word_idx >= 32'(DEPTH));
   assign w_load_data     = readdata;
   assign w_unused_signed = req_signed;
`endif

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               if (w_req_err)       w_next = ST_RESP;
               else if (!req_write) w_next = ST_RD;
               else begin
`ifdef DMEM_SUBWORD_EN
                  w_next = (req_size == SZ_WORD) ? ST_WR : ST_RMW_RD;
`else
                  w_next = ST_WR;
`endif
               end
            end
         end
         ST_RD:     w_next = ST_RESP;
         ST_WR:     w_next = ST_RESP;
`ifdef DMEM_SUBWORD_EN
         ST_RMW_RD: w_next = ST_RMW_WR;
         ST_RMW_WR: w_next = ST_RESP;
`endif
         ST_RESP:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Memory-side and response outputs are registered from the next state, so each
   // strobe is a clean flop output lasting exactly one state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_memread    <= 1'b0;
         r_memwrite   <= 1'b0;
         r_address    <= '0;
         r_writedata  <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_memread    <= (w_next == ST_RD) || (w_next == ST_RMW_RD);
         r_memwrite   <= (w_next == ST_WR) || (w_next == ST_RMW_WR);
         r_resp_valid <= (w_next == ST_RESP);

         if (w_accept) begin
            r_address   <= w_word_idx;
            r_writedata <= req_wdata;
         end
`ifdef DMEM_SUBWORD_EN
         if (r_state == ST_RMW_RD) r_writedata <= w_merged;
`endif

         if (w_next == ST_RESP) begin
            r_resp_err   <= (r_state == ST_IDLE);
            r_resp_rdata <= (r_state == ST_RD) ? w_load_data : '0;
         end else begin
            r_resp_err   <= 1'b0;
         end
      end
   end

   assign req_ready  = (r_state == ST_IDLE);
   assign memread    = r_memread;
   assign memwrite   = r_memwrite;
   assign address    = r_address;
   assign writedata  = r_writedata;
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit against a word memory preloaded with mem[i] = i*10.
// Sub-word cases run when DMEM_SUBWORD_EN is defined; otherwise the word-only rejection is checked.
module tb_dmem_access_unit;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        memread;
   logic        memwrite;
   logic [31:0] address;
   logic [31:0] writedata;
   logic [31:0] readdata;

   logic [31:0] mem [128];
   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_access_unit #(.DATA_W(32), .DEPTH(128)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .memread    (memread),
      .memwrite   (memwrite),
      .address    (address),
      .writedata  (writedata),
      .readdata   (readdata)
   );

   assign readdata = (address < 32'd128) ? mem[address[6:0]] : 32'h0;

   always @(posedge clk) begin
      if (memwrite && address < 32'd128) mem[address[6:0]] <= writedata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives a request for one cycle; returns 1ns after the accepting edge.
   task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'(i * 10);
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = SZ_WORD;
      req_signed = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      check("rst_ready",     32'(req_ready),  32'd1);
      check("rst_resp_vld",  32'(resp_valid), 32'd0);
      check("rst_rdata",     resp_rdata,      32'h0);
      check("rst_err",       32'(resp_err),   32'd0);
      check("rst_memread",   32'(memread),    32'd0);
      check("rst_memwrite",  32'(memwrite),   32'd0);
      check("rst_address",   address,         32'h0);
      check("rst_writedata", writedata,       32'h0);
      rst = 1'b0;

      // Word load 0x14 -> 50
      issue(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0);
      @(negedge clk);
      check("ldw_memread",  32'(memread),    32'd1);
      check("ldw_memwrite", 32'(memwrite),   32'd0);
      check("ldw_address",  address,         32'd5);
      check("ldw_ready",    32'(req_ready),  32'd0);
      check("ldw_vld_early",32'(resp_valid), 32'd0);
      @(negedge clk);
      check("ldw_memread_off", 32'(memread), 32'd0);
      check("ldw_resp_vld", 32'(resp_valid), 32'd1);
      check("ldw_rdata",    resp_rdata,      32'd50);
      check("ldw_err",      32'(resp_err),   32'd0);
      @(negedge clk);
      check("ldw_vld_pulse", 32'(resp_valid), 32'd0);

      // Word store 0xDEADBEEF at 0x20, then read back
      issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hDEADBEEF);
      @(negedge clk);
      check("stw_memwrite",  32'(memwrite),  32'd1);
      check("stw_memread",   32'(memread),   32'd0);
      check("stw_address",   address,        32'd8);
      check("stw_writedata", writedata,      32'hDEADBEEF);
      @(negedge clk);
      check("stw_memwrite_off", 32'(memwrite), 32'd0);
      check("stw_resp_vld",  32'(resp_valid), 32'd1);
      check("stw_rdata",     resp_rdata,      32'h0);
      issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("ldback_vld",   32'(resp_valid), 32'd1);
      check("ldback_rdata", resp_rdata,      32'hDEADBEEF);

      // Misaligned word load
      issue(1'b0, SZ_WORD, 1'b0, 32'h16, 32'h0);
      @(negedge clk);
      check("mis_resp_vld", 32'(resp_valid), 32'd1);
      check("mis_err",      32'(resp_err),   32'd1);
      check("mis_rdata",    resp_rdata,      32'h0);
      check("mis_memread",  32'(memread),    32'd0);
      check("mis_memwrite", 32'(memwrite),   32'd0);
      @(negedge clk);
      check("mis_vld_pulse", 32'(resp_valid), 32'd0);

      // Out-of-range word load (word index 128)
      issue(1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0);
      @(negedge clk);
      check("oor_resp_vld", 32'(resp_valid), 32'd1);
      check("oor_err",      32'(resp_err),   32'd1);
      check("oor_rdata",    resp_rdata,      32'h0);
      check("oor_memread",  32'(memread),    32'd0);
      @(negedge clk);

`ifdef DMEM_SUBWORD_EN
      // Byte store 0xAB at 0x29: word 10 (0x64) becomes 0x0000AB64
      issue(1'b1, SZ_BYTE, 1'b0, 32'h29, 32'h000000AB);
      @(negedge clk);
      check("stb_memread",  32'(memread),    32'd1);
      check("stb_memwrite", 32'(memwrite),   32'd0);
      check("stb_address",  address,         32'd10);
      @(negedge clk);
      check("stb_memwrite2", 32'(memwrite),  32'd1);
      check("stb_memread2",  32'(memread),   32'd0);
      check("stb_merged",   writedata,       32'h0000AB64);
      check("stb_vld_early",32'(resp_valid), 32'd0);
      @(negedge clk);
      check("stb_resp_vld", 32'(resp_valid), 32'd1);
      check("stb_err",      32'(resp_err),   32'd0);
      issue(1'b0, SZ_BYTE, 1'b1, 32'h29, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("ldb_s_rdata",  resp_rdata,      32'hFFFFFFAB);
      issue(1'b0, SZ_BYTE, 1'b0, 32'h29, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("ldb_u_rdata",  resp_rdata,      32'h000000AB);
      // Signed half from lower lane of 0x0000AB64 -> 0xFFFFAB64
      issue(1'b0, SZ_HALF, 1'b1, 32'h28, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("ldh_s_rdata",  resp_rdata,      32'hFFFFAB64);
      // Misaligned half
      issue(1'b0, SZ_HALF, 1'b0, 32'h29, 32'h0);
      @(negedge clk);
      check("ldh_mis_err",  32'(resp_err),   32'd1);
      check("ldh_mis_rd",   32'(memread),    32'd0);
      @(negedge clk);
`else
      // Sub-word access rejected in the word-only build
      issue(1'b0, SZ_HALF, 1'b0, 32'h04, 32'h0);
      @(negedge clk);
      check("half_resp_vld", 32'(resp_valid), 32'd1);
      check("half_err",      32'(resp_err),   32'd1);
      check("half_memread",  32'(memread),    32'd0);
      check("half_rdata",    resp_rdata,      32'h0);
      @(negedge clk);
`endif

      // Reset asserted during the WR cycle
      issue(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h12345678);
      #1;
      check("rstwr_memwrite_on", 32'(memwrite), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("rstwr_memwrite_off", 32'(memwrite),  32'd0);
      check("rstwr_ready",        32'(req_ready), 32'd1);
      check("rstwr_resp_vld",     32'(resp_valid),32'd0);
      @(posedge clk);
      #1;
      check("rstwr_no_resp",      32'(resp_valid),32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rstwr_after_vld",    32'(resp_valid),32'd0);
      check("rstwr_after_ready",  32'(req_ready), 32'd1);
      issue(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("rstwr_mem_intact",   resp_rdata,     32'd120);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
